// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register index type, opcode
// constants and small helpers used by the pipeline stages.
package cpu_pkg;

   localparam int ADDR_W   = 64;
   localparam int INSTR_W  = 32;
   localparam int REG_W    = 5;
   localparam int ZERO_REG = 31;

   // Architectural register index.
   typedef logic [REG_W-1:0] reg_idx_t;

   // Opcode prefixes of the two formats whose Rt field is read, not written.
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;

   // Source register fields of an instruction as seen by the hazard logic.
   typedef struct packed {
      reg_idx_t rn;
      reg_idx_t rm;
      reg_idx_t rt;
      logic     rt_is_src;
   } src_regs_t;

   // Pull the source fields out of an instruction word. Rn and Rm are taken
   // for every format; Rt only counts where the instruction reads it.
   function automatic src_regs_t decode_sources(input logic [INSTR_W-1:0] instr);
      src_regs_t s;
      s.rn        = instr[9:5];
      s.rm        = instr[20:16];
      s.rt        = instr[4:0];
      s.rt_is_src = (instr[31:21] == OP_STUR) || (instr[31:24] == OP_CBZ);
      return s;
   endfunction

   // Increment a counter of the given width, sticking at all-ones.
   function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                           input int unsigned width);
      logic [63:0] max_val;
      if (width >= 64) begin
         max_val = '1;
      end else begin
         max_val = (64'd1 << width) - 64'd1;
      end
      return (value >= max_val) ? value : value + 64'd1;
   endfunction

endpackage : cpu_pkg

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads the
// register that the load currently in EX has not yet produced.
module hazard_detect
   import cpu_pkg::*;
(
   input  logic [INSTR_W-1:0] id_instr,
   input  logic               id_valid,
   input  logic               ex_mem_read,
   input  reg_idx_t           ex_rd,
   output logic               load_use
);

   src_regs_t src;
   logic      rd_live;
   logic      any_match;

   // Bits [15:10] (shamt / imm) never name a register.
   logic      unused_instr_bits;
   assign unused_instr_bits = ^id_instr[15:10];

   assign src = decode_sources(id_instr);

   // Compare the load destination against every source field of ID.
   always_comb begin
      // NOTE: every output of an always_comb gets a default first; a path that
      // leaves one unassigned would infer a latch.
      rd_live   = 1'b0;
      any_match = 1'b0;
      load_use  = 1'b0;

      // XZR reads as zero, so a load targeting it never creates a dependency.
      rd_live = ex_mem_read && (ex_rd != reg_idx_t'(ZERO_REG));

      // Rn and Rm are matched regardless of format; extra stalls are harmless.
      any_match = (src.rn == ex_rd) || (src.rm == ex_rd)
                  || (src.rt_is_src && (src.rt == ex_rd));

      // A bubble in ID (id_valid=0) never stalls.
      load_use = id_valid && rd_live && any_match;
   end

endmodule : hazard_detect

// File: rtl/if_id_stage.sv
// IF/ID pipeline register. Captures the fetched PC/instruction, freezes fetch
// on load-use hazards, turns taken-branch flushes into bubbles, and keeps
// saturating stall/flush event counters for performance debug.
module if_id_stage
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  if_pc,
   input  logic [INSTR_W-1:0] if_instr,
   input  logic               if_valid,
   input  logic               ext_stall,
   input  logic               flush,
   input  logic               ex_mem_read,
   input  logic [REG_W-1:0]   ex_rd,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc_plus4,
   output logic [INSTR_W-1:0] id_instr,
   output logic               id_valid,
   output logic               pc_write_en,
   output logic               id_ex_bubble,
   output logic [CNT_W-1:0]   stall_count,
   output logic [CNT_W-1:0]   flush_count
);

   logic [ADDR_W-1:0]  pc_q;
   logic [INSTR_W-1:0] instr_q;
   logic               valid_q;
   logic [CNT_W-1:0]   stall_cnt_q;
   logic [CNT_W-1:0]   flush_cnt_q;

   logic               load_use;
   logic               stall;

   hazard_detect u_hazard_detect (
      .id_instr    (instr_q),
      .id_valid    (valid_q),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (reg_idx_t'(ex_rd)),
      .load_use    (load_use)
   );

   // Freeze fetch on any stall; ask ID/EX for a bubble on a load-use stall
   // unless the slot is being flushed anyway.
   always_comb begin
      stall        = ext_stall | load_use;
      pc_write_en  = ~stall;
      id_ex_bubble = load_use & ~flush;
   end

   // Pipeline registers: flush beats stall, stall holds, otherwise advance.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; the async reset clears the slot immediately.
      if (!reset) begin
         pc_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else if (flush) begin
         // Keep the PC of the discarded fetch visible for debug.
         pc_q    <= if_pc;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else if (!stall) begin
         pc_q    <= if_pc;
         instr_q <= if_instr;
         valid_q <= if_valid;
      end
   end

   // Event counters; a flushed cycle counts only as a flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (flush) begin
         flush_cnt_q <= CNT_W'(sat_inc(64'(flush_cnt_q), CNT_W));
      end else if (stall) begin
         stall_cnt_q <= CNT_W'(sat_inc(64'(stall_cnt_q), CNT_W));
      end
   end

   // Deriving PC+4 from the held PC keeps it consistent on every path,
   // including reset (0 + 4 = 4) and the 64-bit wrap at the top of memory.
   assign id_pc_plus4 = pc_q + ADDR_W'(4);
   assign id_pc       = pc_q;
   assign id_instr    = instr_q;
   assign id_valid    = valid_q;
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule : if_id_stage

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage with a behavioural reference model.
module tb_if_id_stage;

   localparam int CNT_MAX = 65535;

   logic        clk;
   logic        reset;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        ext_stall;
   logic        flush;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic [63:0] id_pc;
   logic [63:0] id_pc_plus4;
   logic [31:0] id_instr;
   logic        id_valid;
   logic        pc_write_en;
   logic        id_ex_bubble;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   logic [63:0] m_pc;
   logic [31:0] m_instr;
   bit          m_valid;
   int          m_stall;
   int          m_flush;

   if_id_stage #(.CNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .if_pc        (if_pc),
      .if_instr     (if_instr),
      .if_valid     (if_valid),
      .ext_stall    (ext_stall),
      .flush        (flush),
      .ex_mem_read  (ex_mem_read),
      .ex_rd        (ex_rd),
      .id_pc        (id_pc),
      .id_pc_plus4  (id_pc_plus4),
      .id_instr     (id_instr),
      .id_valid     (id_valid),
      .pc_write_en  (pc_write_en),
      .id_ex_bubble (id_ex_bubble),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Does the instruction in ID read the register a pending load writes?
   function automatic bit model_hazard(input logic [31:0] instr, input bit valid,
                                       input bit mr, input logic [4:0] rd);
      logic [4:0] srcs[$];
      bit hit;
      hit = 0;
      if (!valid || !mr || rd == 5'd31) return 0;
      srcs.push_back(instr[9:5]);
      srcs.push_back(instr[20:16]);
      if (instr[31:21] == 11'h7C0 || instr[31:24] == 8'hB4) srcs.push_back(instr[4:0]);
      foreach (srcs[i]) if (srcs[i] == rd) hit = 1;
      return hit;
   endfunction

   task automatic clear_inputs();
      if_pc = '0; if_instr = '0; if_valid = 0; ext_stall = 0;
      flush = 0; ex_mem_read = 0; ex_rd = '0;
   endtask

   task automatic model_clear();
      m_pc = '0; m_instr = '0; m_valid = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 0;
      clear_inputs();
      model_clear();
      #2 reset = 1;
   endtask

   // Advance the model by one clock using the current inputs, then the DUT.
   task automatic step();
      bit hz;
      hz = model_hazard(m_instr, m_valid, ex_mem_read, ex_rd);
      if (flush) begin
         m_pc = if_pc; m_instr = '0; m_valid = 0;
         if (m_flush < CNT_MAX) m_flush++;
      end else if (ext_stall || hz) begin
         if (m_stall < CNT_MAX) m_stall++;
      end else begin
         m_pc = if_pc; m_instr = if_instr; m_valid = if_valid;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_tests++; if (id_pc !== 64'd0) begin n_fail++; $display("FAIL reset_id_pc got %h exp 0", id_pc); end
      n_tests++; if (id_pc_plus4 !== 64'd4) begin n_fail++; $display("FAIL reset_pc_plus4 got %h exp 4", id_pc_plus4); end
      n_tests++; if (id_instr !== 32'd0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_slot got instr %h valid %b exp 0/0", id_instr, id_valid); end
      n_tests++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d exp 0/0", stall_count, flush_count); end
      n_tests++; if (pc_write_en !== 1'b1 || id_ex_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_comb got pwe %b bub %b exp 1/0", pc_write_en, id_ex_bubble); end
   endtask

   task automatic test_stream();
      logic [31:0] prog[3];
      prog[0] = 32'hF8400020; prog[1] = 32'hF8400041; prog[2] = 32'h8B020023;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         if_pc = 64'(i * 4); if_instr = prog[i]; if_valid = 1;
         #1;
         n_tests++; if (pc_write_en !== 1'b1) begin n_fail++; $display("FAIL stream_pwe[%0d] got %b exp 1", i, pc_write_en); end
         step();
         n_tests++; if (id_pc !== 64'(i * 4) || id_instr !== prog[i] || id_valid !== 1'b1) begin
            n_fail++; $display("FAIL stream_slot[%0d] got pc %h instr %h v %b exp pc %h instr %h v 1", i, id_pc, id_instr, id_valid, 64'(i * 4), prog[i]);
         end
         n_tests++; if (id_pc_plus4 !== 64'(i * 4 + 4)) begin n_fail++; $display("FAIL stream_plus4[%0d] got %h exp %h", i, id_pc_plus4, 64'(i * 4 + 4)); end
      end
      // Top-of-memory wrap.
      if_pc = 64'hFFFF_FFFF_FFFF_FFFC; step();
      n_tests++; if (id_pc_plus4 !== 64'd0) begin n_fail++; $display("FAIL pc_wrap got %h exp 0", id_pc_plus4); end
   endtask

   // Put one instruction into ID, then present a load in EX and check the outcome.
   task automatic hazard_case(input string name, input logic [31:0] instr,
                              input logic [4:0] rd, input bit exp_stall);
      do_reset();
      if_pc = 64'h100; if_instr = instr; if_valid = 1; step();
      if_pc = 64'h104; if_instr = 32'h8B1F03E0;
      ex_mem_read = 1; ex_rd = rd;
      #1;
      n_tests++; if (pc_write_en !== !exp_stall || id_ex_bubble !== exp_stall) begin
         n_fail++; $display("FAIL %s_comb got pwe %b bub %b exp %b/%b", name, pc_write_en, id_ex_bubble, !exp_stall, exp_stall);
      end
      step();
      n_tests++; if (id_pc !== m_pc || id_instr !== m_instr || stall_count !== 16'(m_stall)) begin
         n_fail++; $display("FAIL %s_regs got pc %h instr %h sc %0d exp %h %h %0d", name, id_pc, id_instr, stall_count, m_pc, m_instr, m_stall);
      end
      // The load has moved on; the stall must not persist.
      ex_mem_read = 0; #1;
      n_tests++; if (pc_write_en !== 1'b1) begin n_fail++; $display("FAIL %s_release got pwe %b exp 1", name, pc_write_en); end
      clear_inputs();
   endtask

   task automatic test_load_use();
      hazard_case("lu_rn",   32'h8B0600A3, 5'd5,  1);  // ADD X3,X5,X6 ; load X5
      n_tests++; if (stall_count !== 16'd1 || id_pc !== 64'h100) begin
         n_fail++; $display("FAIL lu_rn_hold got sc %0d pc %h exp 1 100", stall_count, id_pc);
      end
      hazard_case("lu_xzr",  32'h8B0603E3, 5'd31, 0);  // Rn=XZR ; load XZR
      hazard_case("lu_stur", 32'hF8000047, 5'd7,  1);  // STUR X7,[X2]
      hazard_case("lu_add_rd", 32'h8B020027, 5'd7, 0); // ADD X7,X1,X2
   endtask

   task automatic test_flush_stall();
      int sc_before;
      do_reset();
      if_pc = 64'h40; if_instr = 32'hF8000047; if_valid = 1; step();
      sc_before = stall_count;
      if_pc = 64'h44; if_instr = 32'h8B020027; ext_stall = 1; flush = 1;
      ex_mem_read = 1; ex_rd = 5'd7;
      #1;
      n_tests++; if (id_ex_bubble !== 1'b0 || pc_write_en !== 1'b0) begin
         n_fail++; $display("FAIL flush_comb got bub %b pwe %b exp 0/0", id_ex_bubble, pc_write_en);
      end
      step();
      n_tests++; if (id_valid !== 1'b0 || id_instr !== 32'd0 || id_pc !== 64'h44) begin
         n_fail++; $display("FAIL flush_slot got v %b instr %h pc %h exp 0 0 44", id_valid, id_instr, id_pc);
      end
      n_tests++; if (flush_count !== 16'd1 || stall_count !== 16'(sc_before)) begin
         n_fail++; $display("FAIL flush_counts got fc %0d sc %0d exp 1 %0d", flush_count, stall_count, sc_before);
      end
      // Flushed slot never stalls even with a matching load.
      flush = 0; ext_stall = 0; #1;
      n_tests++; if (pc_write_en !== 1'b1) begin n_fail++; $display("FAIL flush_bubble_nostall got pwe %b exp 1", pc_write_en); end
      clear_inputs();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      if_pc = 64'h200; if_instr = 32'h8B0600A3; if_valid = 1; step();
      ex_mem_read = 1; ex_rd = 5'd5; step();
      #2;
      reset = 0; ext_stall = 0;
      #1;
      n_tests++; if (id_pc !== 64'd0 || id_pc_plus4 !== 64'd4 || id_instr !== 32'd0 || id_valid !== 1'b0) begin
         n_fail++; $display("FAIL async_reset_slot got pc %h p4 %h instr %h v %b", id_pc, id_pc_plus4, id_instr, id_valid);
      end
      n_tests++; if (stall_count !== 16'd0 || id_ex_bubble !== 1'b0 || pc_write_en !== 1'b1) begin
         n_fail++; $display("FAIL async_reset_misc got sc %0d bub %b pwe %b exp 0 0 1", stall_count, id_ex_bubble, pc_write_en);
      end
      @(negedge clk);
      reset = 1;
      clear_inputs();
      model_clear();
   endtask

   task automatic test_random();
      logic [31:0] instr;
      bit          hz;
      int          errs;
      errs = 0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: instr = {11'h7C0, 9'($urandom), 2'b00, 5'($urandom), 5'($urandom)};
            1: instr = {8'hB4, 19'($urandom), 5'($urandom)};
            2: instr = {11'h458, 5'($urandom), 6'd0, 5'($urandom), 5'($urandom)};
            default: instr = $urandom;
         endcase
         if_pc       = {$urandom, $urandom};
         if_instr    = instr;
         if_valid    = ($urandom_range(0, 7) != 0);
         flush       = ($urandom_range(0, 7) == 0);
         ext_stall   = ($urandom_range(0, 7) == 0);
         ex_mem_read = $urandom_range(0, 1);
         case ($urandom_range(0, 4))
            0: ex_rd = m_instr[9:5];
            1: ex_rd = m_instr[20:16];
            2: ex_rd = m_instr[4:0];
            3: ex_rd = 5'd31;
            default: ex_rd = 5'($urandom);
         endcase
         hz = model_hazard(m_instr, m_valid, ex_mem_read, ex_rd);
         #1;
         n_tests++; if (pc_write_en !== !(ext_stall || hz) || id_ex_bubble !== (hz && !flush)) begin
            n_fail++; errs++;
            if (errs < 10) $display("FAIL rand_comb[%0d] got pwe %b bub %b exp %b %b", i, pc_write_en, id_ex_bubble, !(ext_stall || hz), hz && !flush);
         end
         step();
         n_tests++; if (id_pc !== m_pc || id_pc_plus4 !== m_pc + 64'd4 || id_instr !== m_instr || id_valid !== m_valid
                         || stall_count !== 16'(m_stall) || flush_count !== 16'(m_flush)) begin
            n_fail++; errs++;
            if (errs < 10) $display("FAIL rand_regs[%0d] got pc %h instr %h v %b sc %0d fc %0d exp %h %h %b %0d %0d",
                                    i, id_pc, id_instr, id_valid, stall_count, flush_count, m_pc, m_instr, m_valid, m_stall, m_flush);
         end
      end
      clear_inputs();
   endtask

   task automatic test_saturation();
      do_reset();
      ext_stall = 1;
      repeat (70000) @(posedge clk);
      #1;
      n_tests++; if (stall_count !== 16'hFFFF || flush_count !== 16'd0) begin
         n_fail++; $display("FAIL sat_stall got sc %h fc %h exp FFFF 0", stall_count, flush_count);
      end
      repeat (10) @(posedge clk);
      #1;
      n_tests++; if (stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h exp FFFF", stall_count); end
      clear_inputs();
   endtask

   initial begin
      reset = 1;
      clear_inputs();
      model_clear();
      test_reset();
      test_stream();
      test_load_use();
      test_flush_stall();
      test_reset_mid_stall();
      test_random();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_if_id_stage
